// File: rtl/mrsc_pkg.sv
// mrsc_pkg: MRSC codeword layout, syndrome type and the check-bit generator shared by encoder and decoder.
// Data bit s[b][j] lives at cw[4j+b]; check fields follow at cw[16:31].
package mrsc_pkg;

  typedef struct packed {
    logic [3:0]      di;
    logic [3:0]      p;
    logic [3:0][1:0] cb;
  } mrsc_syn_t;

  localparam int DATA_W  = 16;
  localparam int CW_W    = 32;
  // Di and P fields are stored in 0,3,1,2 order
  localparam int DI_POS [4] = '{16, 18, 19, 17};
  localparam int P_POS  [4] = '{20, 22, 23, 21};
  localparam int CB_BASE = 24;

  function automatic int s_pos(input int b, input int j);
    return 4 * j + b;
  endfunction

  function automatic mrsc_syn_t mrsc_gen_checks(input logic [0:DATA_W-1] d);
    mrsc_syn_t c;
    c = '0;
    for (int j = 0; j < 4; j++) begin
      c.p[j]  = d[s_pos(0, j)] ^ d[s_pos(1, j)] ^ d[s_pos(2, j)] ^ d[s_pos(3, j)];
      c.di[j] = d[s_pos(0, j)] ^ d[s_pos(1, j ^ 1)] ^ d[s_pos(2, j)] ^ d[s_pos(3, j ^ 1)];
    end
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 2; k++) begin
        c.cb[b][k] = d[s_pos(b, k)] ^ d[s_pos(b, k + 2)];
      end
    end
    return c;
  endfunction

  function automatic mrsc_syn_t mrsc_rx_checks(input logic [0:CW_W-1] cw);
    mrsc_syn_t c;
    c = '0;
    for (int j = 0; j < 4; j++) begin
      c.di[j] = cw[DI_POS[j]];
      c.p[j]  = cw[P_POS[j]];
    end
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 2; k++) begin
        c.cb[b][k] = cw[CB_BASE + 2 * b + k];
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/mrsc_syndrome.sv
// mrsc_syndrome: combinational check-bit regeneration; syndrome = received checks XOR recomputed checks.
module mrsc_syndrome
  import mrsc_pkg::*;
(
  input  logic [0:31] cw,
  output mrsc_syn_t   syn
);

  assign syn = mrsc_rx_checks(cw) ^ mrsc_gen_checks(cw[0:15]);

endmodule

// File: rtl/mrsc_decoder.sv
// mrsc_decoder: 2-stage valid/ready MRSC decoder with single-bit correction and saturating error counters.
// Define MRSC_ERR_LOG_EN to capture the first uncorrectable codeword on log_valid/log_cw.
module mrsc_decoder
  import mrsc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:31]      cw_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [0:15]      data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr,
  input  logic             cnt_clr,
  output logic             log_valid,
  output logic [0:31]      log_cw
);

  logic        s1_valid_r;
  logic [0:15] s1_data_r;
  mrsc_syn_t   s1_syn_r;
  mrsc_syn_t   syn_s;
  logic        s2_advance_s;
  logic        in_xfer_s;
  logic        out_xfer_s;
  logic [4:0]  pop_s;
  logic [0:15] flip_s;
  logic [0:15] corr_data_s;
  logic        corr_s;
  logic        uncorr_s;

  mrsc_syndrome u_syndrome (
    .cw  (cw_in),
    .syn (syn_s)
  );

  assign s2_advance_s = !out_valid || out_ready;
  assign in_ready     = !s1_valid_r || s2_advance_s;
  assign in_xfer_s    = in_valid && in_ready;
  assign out_xfer_s   = out_valid && out_ready;

  // Stage 1: capture data field and syndrome of the accepted codeword
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
      s1_syn_r   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_r <= in_valid;
      end
      if (in_xfer_s) begin
        s1_data_r <= cw_in[0:15];
        s1_syn_r  <= syn_s;
      end
    end
  end

  // Correction: a weight-3 syndrome naming exactly one data bit flips it; data_out is row-major
  always_comb begin
    pop_s       = 5'($countones(s1_syn_r));
    flip_s      = '0;
    corr_data_s = '0;
    corr_s      = 1'b0;
    uncorr_s    = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 4; j++) begin
        flip_s[4*b+j] = (pop_s == 5'd3) && s1_syn_r.cb[b][j & 1] && s1_syn_r.p[j]
                        && s1_syn_r.di[(b % 2 == 0) ? j : (j ^ 1)];
        corr_data_s[4*b+j] = s1_data_r[s_pos(b, j)] ^ flip_s[4*b+j];
      end
    end
    if (pop_s == 5'd0) begin
      corr_s   = 1'b0;
      uncorr_s = 1'b0;
    end else if ((pop_s == 5'd1) || (|flip_s)) begin
      corr_s   = 1'b1;
      uncorr_s = 1'b0;
    end else begin
      corr_s   = 1'b0;
      uncorr_s = 1'b1;
    end
  end

  // Stage 2: output register, held stable while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
    end else if (s2_advance_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        data_out   <= corr_data_s;
        err_corr   <= corr_s;
        err_uncorr <= uncorr_s;
      end
    end
  end

  // Saturating counters; clear has priority over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (cnt_clr) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (out_xfer_s) begin
      if (err_corr && (cnt_corr != '1)) begin
        cnt_corr <= cnt_corr + CNT_W'(1);
      end
      if (err_uncorr && (cnt_uncorr != '1)) begin
        cnt_uncorr <= cnt_uncorr + CNT_W'(1);
      end
    end
  end

`ifdef MRSC_ERR_LOG_EN
  logic [16:31] s1_chk_r;
  logic [0:31]  s2_cw_r;

  // Raw codeword travels alongside the pipeline so the log can hold it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_chk_r <= '0;
      s2_cw_r  <= '0;
    end else begin
      if (in_xfer_s) begin
        s1_chk_r <= cw_in[16:31];
      end
      if (s2_advance_s && s1_valid_r) begin
        s2_cw_r <= {s1_data_r, s1_chk_r};
      end
    end
  end

  // Sticky capture of the first uncorrectable word seen at the output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_valid <= 1'b0;
      log_cw    <= '0;
    end else if (cnt_clr) begin
      log_valid <= 1'b0;
      log_cw    <= '0;
    end else if (out_xfer_s && err_uncorr && !log_valid) begin
      log_valid <= 1'b1;
      log_cw    <= s2_cw_r;
    end
  end
`else
  assign log_valid = 1'b0;
  assign log_cw    = '0;
`endif

endmodule
